// File: rtl/pd_ctrl.sv
// Round/phase sequencer for an iterated block datapath: loads four words, runs NR rounds
// of four-word groups, then drains the pipeline, steering the delay-line tap muxes throughout.
module pd_ctrl #(
    parameter int NR = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] sel1,
    output logic       sel2,
    output logic       load_en,
    output logic [4:0] round_idx,
    output logic [1:0] phase,
    output logic       busy,
    output logic       out_valid,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        LAST  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [4:0] RoundPen  = 5'(NR - 2);
    localparam logic [4:0] RoundLast = 5'(NR - 1);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [4:0] round_q, round_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] sel1_q, sel1_d;
    logic       sel2_q, sel2_d;
    logic       load_en_q, load_en_d;
    logic       busy_q, busy_d;
    logic       out_valid_q, out_valid_d;
    logic       done_q, done_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        round_d     = round_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        sel1_d      = 2'b00;
        sel2_d      = 1'b0;
        load_en_d   = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = 2'd0;
                round_d = 5'd0;
                cnt_d   = 3'd0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d = ROUND;
                    round_d = 5'd0;
                end
            end
            ROUND: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    if (round_q == RoundPen) begin
                        state_d = LAST;
                        round_d = RoundLast;
                    end else begin
                        round_d = round_q + 5'd1;
                    end
                end
            end
            LAST: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d = DRAIN;
                    cnt_d   = 3'd0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    round_d = 5'd0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they land in registers aligned with it.
        busy_d      = (state_d != IDLE);
        load_en_d   = (state_d == LOAD);
        sel2_d      = (state_d == ROUND) || (state_d == LAST);
        out_valid_d = (state_d == DRAIN) && (cnt_d >= 3'd2);
        if (state_d == ROUND) begin
            case (phase_d)
                2'd0:    sel1_d = 2'b01;
                2'd2:    sel1_d = 2'b10;
                default: sel1_d = 2'b00;
            endcase
        end else if (state_d == LAST) begin
            case (phase_d)
                2'd1:    sel1_d = 2'b01;
                2'd3:    sel1_d = 2'b10;
                default: sel1_d = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            round_q     <= 5'd0;
            cnt_q       <= 3'd0;
            sel1_q      <= 2'b00;
            sel2_q      <= 1'b0;
            load_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            load_en_q   <= load_en_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign sel1      = sel1_q;
    assign sel2      = sel2_q;
    assign load_en   = load_en_q;
    assign round_idx = round_q;
    assign phase     = phase_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pd_ctrl.sv
// Scoreboarded bench for pd_ctrl: an NR=18 and an NR=2 instance are predicted from a
// cycle-count model of the block timeline and compared every cycle on the falling edge.
module tb_pd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst18, start18, rst2, start2;
    logic [1:0] sel1_18, sel1_2, phase18, phase2;
    logic       sel2_18, sel2_2, ld18_o, ld2_o, busy18, busy2, ov18, ov2, done18, done2;
    logic [4:0] rnd18, rnd2;

    pd_ctrl #(.NR(18)) u18 (
        .clk(clk), .rst(rst18), .start(start18), .sel1(sel1_18), .sel2(sel2_18),
        .load_en(ld18_o), .round_idx(rnd18), .phase(phase18), .busy(busy18),
        .out_valid(ov18), .done(done18)
    );

    pd_ctrl #(.NR(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .sel1(sel1_2), .sel2(sel2_2),
        .load_en(ld2_o), .round_idx(rnd2), .phase(phase2), .busy(busy2),
        .out_valid(ov2), .done(done2)
    );

    typedef struct packed {
        logic [1:0] sel1;
        logic       sel2;
        logic       load_en;
        logic [4:0] round_idx;
        logic [1:0] phase;
        logic       busy;
        logic       out_valid;
        logic       done;
    } obs_t;

    obs_t q18[$];
    obs_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bit act18 = 0, dn18 = 0, act2 = 0, dn2 = 0;
    int t18 = 0, t2 = 0;

    int s18_at, d18_at, nd18, ld18, bz18, ovn18, ovfirst18, ovlast18;
    int s2_first, d2_first, d2_last, nd2;
    logic [1:0] tr_sel1[0:127];
    logic       tr_sel2[0:127];
    logic [4:0] tr_rnd2[0:63];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic obs_t predict(input int nr, input bit act, input int t, input bit dn);
        obs_t o;
        int   r, u;
        o      = '0;
        o.done = dn;
        if (act) begin
            o.busy = 1'b1;
            r = 4 * (nr - 1);
            if (t < 4) begin
                o.load_en = 1'b1;
                o.phase   = 2'(t);
            end else if (t < 4 + r) begin
                u = t - 4;
                o.sel2      = 1'b1;
                o.round_idx = 5'(u / 4);
                o.phase     = 2'(u % 4);
                o.sel1      = (u % 4 == 0) ? 2'b01 : (u % 4 == 2) ? 2'b10 : 2'b00;
            end else if (t < 8 + r) begin
                u = t - 4 - r;
                o.sel2      = 1'b1;
                o.round_idx = 5'(nr - 1);
                o.phase     = 2'(u);
                o.sel1      = (u == 1) ? 2'b01 : (u == 3) ? 2'b10 : 2'b00;
            end else begin
                u = t - 8 - r;
                o.round_idx = 5'(nr - 1);
                o.out_valid = (u >= 2);
            end
        end
        return o;
    endfunction

    task automatic advance(input int nr, input bit r, input bit s,
                           inout bit act, inout int t, inout bit dn);
        dn = 1'b0;
        if (r) begin
            act = 1'b0;
            t   = 0;
        end else if (!act) begin
            if (s) begin
                act = 1'b1;
                t   = 0;
            end
        end else if (t + 1 == 4 * nr + 10) begin
            act = 1'b0;
            t   = 0;
            dn  = 1'b1;
        end else begin
            t++;
        end
    endtask

    task automatic clear_metrics();
        s18_at = -1000; d18_at = -1; nd18 = 0; ld18 = 0; bz18 = 0;
        ovn18 = 0; ovfirst18 = -1; ovlast18 = -1;
        s2_first = -1; d2_first = -1; d2_last = -1; nd2 = 0;
    endtask

    task automatic step(input bit s18, input bit r18, input bit s2, input bit r2);
        obs_t o, e;
        int   k;
        start18 = s18; rst18 = r18; start2 = s2; rst2 = r2;
        @(posedge clk);
        cyc++;
        if (s18 && !r18 && !act18) s18_at = cyc;
        if (s2 && !r2 && !act2 && s2_first < 0) s2_first = cyc;
        advance(18, r18, s18, act18, t18, dn18);
        advance(2, r2, s2, act2, t2, dn2);
        q18.push_back(predict(18, act18, t18, dn18));
        q2.push_back(predict(2, act2, t2, dn2));
        @(negedge clk);
        o = {sel1_18, sel2_18, ld18_o, rnd18, phase18, busy18, ov18, done18};
        e = q18.pop_front();
        check("cycle_nr18", 32'(o), 32'(e));
        o = {sel1_2, sel2_2, ld2_o, rnd2, phase2, busy2, ov2, done2};
        e = q2.pop_front();
        check("cycle_nr2", 32'(o), 32'(e));
        if (busy18) bz18++;
        if (ld18_o) ld18++;
        if (done18) begin nd18++; d18_at = cyc; end
        if (ov18) begin
            if (ovn18 == 0) ovfirst18 = cyc;
            ovn18++;
            ovlast18 = cyc;
        end
        k = cyc - s18_at;
        if (k >= 0 && k < 128) begin tr_sel1[k] = sel1_18; tr_sel2[k] = sel2_18; end
        if (done2) begin
            nd2++;
            if (d2_first < 0) d2_first = cyc;
            d2_last = cyc;
        end
        k = cyc - s2_first;
        if (s2_first >= 0 && k >= 0 && k < 64) tr_rnd2[k] = rnd2;
    endtask

    task automatic check_block18(input string tag);
        check({tag, "_load_cycles"}, 32'(ld18), 32'd4);
        check({tag, "_busy_cycles"}, 32'(bz18), 32'd82);
        check({tag, "_done_latency"}, 32'(d18_at - s18_at), 32'd82);
        check({tag, "_done_pulses"}, 32'(nd18), 32'd1);
    endtask

    initial begin
        logic [7:0] rd_pat, last_pat;
        rd_pat   = 8'b01_00_10_00;
        last_pat = 8'b00_01_00_10;
        clear_metrics();

        // Reset state
        repeat (3) step(0, 1, 0, 1);
        check("reset_outputs18", 32'({sel1_18, sel2_18, ld18_o, rnd18, phase18, busy18, ov18, done18}), 32'd0);
        check("reset_outputs2", 32'({sel1_2, sel2_2, ld2_o, rnd2, phase2, busy2, ov2, done2}), 32'd0);

        // Single block, NR=18
        clear_metrics();
        step(1, 0, 0, 0);
        repeat (90) step(0, 0, 0, 0);
        check_block18("single");
        check("ov_count", 32'(ovn18), 32'd4);
        check("ov_consecutive", 32'(ovlast18 - ovfirst18 + 1), 32'd4);
        check("ov_end_before_done", 32'(d18_at - ovlast18), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("round0_sel1", 32'(tr_sel1[4 + i]), 32'(rd_pat[7 - 2 * i -: 2]));
            check("round0_sel2", 32'(tr_sel2[4 + i]), 32'd1);
            check("last_sel1", 32'(tr_sel1[72 + i]), 32'(last_pat[7 - 2 * i -: 2]));
        end

        // start pulses during an active block are ignored
        clear_metrics();
        step(1, 0, 0, 0);
        for (int k = 1; k <= 90; k++) step(k == 10 || k == 40, 0, 0, 0);
        check_block18("busy_start");

        // Reset in ROUND with round_idx=7 aborts without done
        clear_metrics();
        step(1, 0, 0, 0);
        repeat (32) step(0, 0, 0, 0);
        check("pre_abort_round", 32'(rnd18), 32'd7);
        step(1, 1, 0, 0);
        check("abort_outputs", 32'({sel1_18, sel2_18, ld18_o, rnd18, phase18, busy18, ov18, done18}), 32'd0);
        repeat (20) step(0, 0, 0, 0);
        check("abort_no_done", 32'(nd18), 32'd0);
        clear_metrics();
        step(1, 0, 0, 0);
        repeat (90) step(0, 0, 0, 0);
        check_block18("after_abort");

        // NR=2 with start held through done: back-to-back blocks
        clear_metrics();
        step(0, 0, 1, 0);
        for (int k = 1; k <= 45; k++) step(0, 0, k <= 19, 0);
        check("nr2_done_latency", 32'(d2_first - s2_first), 32'd18);
        check("nr2_done_pulses", 32'(nd2), 32'd2);
        check("nr2_back_to_back", 32'(d2_last - d2_first), 32'd19);
        check("nr2_round_first", 32'(tr_rnd2[5]), 32'd0);
        check("nr2_round_last", 32'(tr_rnd2[9]), 32'd1);
        check("nr2_round_drain", 32'(tr_rnd2[14]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
